// File: rtl/seg_display_decoder.sv
// Recovers four BCD digits from a multiplexed active-low 7-segment bus, with glitch
// rejection, illegal-pattern/anode flagging and a stale-bus timeout.
module seg_display_decoder #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned TIMEOUT       = 400_000
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [0:6] seg,
    input  logic [3:0] an,
    input  logic       clr_err,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [3:0] thousands,
    output logic [3:0] digit_valid,
    output logic       frame_valid,
    output logic       err,
    output logic [1:0] err_sticky,
    output logic       stale
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] StableMax = CntW'(STABLE_CYCLES);
    localparam logic [CntW-1:0] StablePre = CntW'(STABLE_CYCLES - 1);
    localparam logic [ToW-1:0]  ToLast    = ToW'(TIMEOUT - 1);

    logic [0:6]      seg_q;
    logic [3:0]      an_q;
    logic [CntW-1:0] stab_q, stab_d;
    logic [ToW-1:0]  timer_q;
    logic [3:0]      seen_q;

    logic       sample_same;
    logic       capture;
    logic [3:0] pos;
    logic       an_blank;
    logic       an_bad;
    logic [3:0] digit_val;
    logic       pat_ok;
    logic       accept;
    logic       seg_err;
    logic       an_err;
    logic       frame;

    always_comb begin
        // Compare the incoming pins against the held sample: equal means another stable cycle.
        sample_same = (seg == seg_q) && (an == an_q);
        capture     = sample_same && (stab_q == StablePre);

        stab_d = stab_q;
        if (!sample_same) begin
            stab_d = '0;
        end else if (stab_q != StableMax) begin
            stab_d = stab_q + 1'b1;
        end

        pos      = 4'b0000;
        an_blank = 1'b0;
        an_bad   = 1'b0;
        unique case (an_q)
            4'b1110: pos = 4'b0001;
            4'b1101: pos = 4'b0010;
            4'b1011: pos = 4'b0100;
            4'b0111: pos = 4'b1000;
            4'b1111: an_blank = 1'b1;
            default: an_bad = 1'b1;
        endcase

        digit_val = 4'd0;
        pat_ok    = 1'b1;
        unique case (seg_q)
            7'b0000001: digit_val = 4'd0;
            7'b1001111: digit_val = 4'd1;
            7'b0010010: digit_val = 4'd2;
            7'b0000110: digit_val = 4'd3;
            7'b1001100: digit_val = 4'd4;
            7'b0100100: digit_val = 4'd5;
            7'b0100000: digit_val = 4'd6;
            7'b0001111: digit_val = 4'd7;
            7'b0000000: digit_val = 4'd8;
            7'b0000100: digit_val = 4'd9;
            default:    pat_ok = 1'b0;
        endcase

        // A bad anode code takes precedence: no position is selected, so the pattern is moot.
        an_err  = capture && an_bad;
        seg_err = capture && !an_bad && !an_blank && !pat_ok;
        accept  = capture && !an_bad && !an_blank && pat_ok;
        frame   = accept && ((seen_q | pos) == 4'b1111);
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            seg_q       <= 7'b1111111;
            an_q        <= 4'b1111;
            stab_q      <= '0;
            timer_q     <= '0;
            seen_q      <= 4'b0000;
            ones        <= 4'd0;
            tens        <= 4'd0;
            hundreds    <= 4'd0;
            thousands   <= 4'd0;
            digit_valid <= 4'b0000;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            err_sticky  <= 2'b00;
            stale       <= 1'b0;
        end else begin
            seg_q       <= seg;
            an_q        <= an;
            stab_q      <= stab_d;
            err         <= seg_err | an_err;
            frame_valid <= frame;
            err_sticky  <= (clr_err ? 2'b00 : err_sticky) | {an_err, seg_err};

            if (accept) begin
                if (pos[0]) ones      <= digit_val;
                if (pos[1]) tens      <= digit_val;
                if (pos[2]) hundreds  <= digit_val;
                if (pos[3]) thousands <= digit_val;
                digit_valid <= digit_valid | pos;
                seen_q      <= frame ? 4'b0000 : (seen_q | pos);
                timer_q     <= '0;
                stale       <= 1'b0;
            end else begin
                if (seg_err) begin
                    digit_valid <= digit_valid & ~pos;
                    seen_q      <= seen_q & ~pos;
                end
                // Timer parks at its last value until an accepted capture restarts it.
                if (timer_q == ToLast) begin
                    stale       <= 1'b1;
                    digit_valid <= 4'b0000;
                    seen_q      <= 4'b0000;
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_display_decoder.sv
// Directed bench for seg_display_decoder; small TIMEOUT keeps the stale scenario short.
module tb_seg_display_decoder;

    localparam int unsigned STABLE_CYCLES = 16;
    localparam int unsigned TIMEOUT       = 1000;

    localparam logic [0:6] P0 = 7'b0000001, P2 = 7'b0010010, P3 = 7'b0000110;
    localparam logic [0:6] P4 = 7'b1001100, P5 = 7'b0100100, P6 = 7'b0100000;
    localparam logic [0:6] P7 = 7'b0001111, P8 = 7'b0000000, P9 = 7'b0000100;
    localparam logic [0:6] PBLANK = 7'b1111111;

    logic       clk = 1'b0;
    logic       RESET;
    logic [0:6] seg;
    logic [3:0] an;
    logic       clr_err;
    logic [3:0] ones, tens, hundreds, thousands, digit_valid;
    logic       frame_valid, err, stale;
    logic [1:0] err_sticky;

    int checks   = 0;
    int failures = 0;

    seg_display_decoder #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk        (clk),
        .RESET      (RESET),
        .seg        (seg),
        .an         (an),
        .clr_err    (clr_err),
        .ones       (ones),
        .tens       (tens),
        .hundreds   (hundreds),
        .thousands  (thousands),
        .digit_valid(digit_valid),
        .frame_valid(frame_valid),
        .err        (err),
        .err_sticky (err_sticky),
        .stale      (stale)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds one bus value for n cycles, counting err/frame pulses and the first frame cycle.
    task automatic hold(input logic [3:0] a, input logic [0:6] s, input int n,
                        output int errs, output int frames, output int frame_at);
        an       = a;
        seg      = s;
        errs     = 0;
        frames   = 0;
        frame_at = 0;
        for (int i = 1; i <= n; i++) begin
            tick(1);
            if (err) errs++;
            if (frame_valid) begin
                frames++;
                if (frame_at == 0) frame_at = i;
            end
        end
    endtask

    task automatic test_reset();
        RESET   = 1'b1;
        seg     = PBLANK;
        an      = 4'b1111;
        clr_err = 1'b0;
        tick(3);
        RESET = 1'b0;
        tick(1);
        checks++;
        if ({ones, tens, hundreds, thousands, digit_valid, frame_valid, err, err_sticky, stale}
            !== '0) begin
            failures++;
            $display("FAIL reset_values: got %h %h %h %h dv=%b fv=%b err=%b es=%b stale=%b",
                     ones, tens, hundreds, thousands, digit_valid, frame_valid, err,
                     err_sticky, stale);
        end
    endtask

    task automatic test_latency();
        int errs = 0;
        int frames = 0;
        an  = 4'b1110;
        seg = P7;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (err) errs++;
            if (frame_valid) frames++;
            if (i == 16) begin
                checks++;
                if (digit_valid !== 4'b0000) begin
                    failures++;
                    $display("FAIL latency_early: dv=%b required 0000", digit_valid);
                end
            end
            if (i == 17) begin
                checks++;
                if (ones !== 4'd7 || digit_valid !== 4'b0001) begin
                    failures++;
                    $display("FAIL latency_capture: ones=%0d dv=%b required 7 0001",
                             ones, digit_valid);
                end
            end
        end
        checks++;
        if (errs !== 0 || frames !== 0) begin
            failures++;
            $display("FAIL latency_pulses: errs=%0d frames=%0d required 0 0", errs, frames);
        end
    endtask

    task automatic test_frames();
        int e, f, fa;
        int e_tot;
        for (int round = 0; round < 2; round++) begin
            e_tot = 0;
            hold(4'b1110, P9, 200, e, f, fa); e_tot += e;
            checks++;
            if (f !== 0) begin failures++; $display("FAIL frame_ones: frames=%0d required 0", f); end
            hold(4'b1101, P5, 200, e, f, fa); e_tot += e;
            hold(4'b1011, P2, 200, e, f, fa); e_tot += e;
            checks++;
            if (f !== 0) begin failures++; $display("FAIL frame_hund: frames=%0d required 0", f); end
            hold(4'b0111, P8, 200, e, f, fa); e_tot += e;
            checks++;
            if (f !== 1 || fa !== 17) begin
                failures++;
                $display("FAIL frame_pulse r%0d: frames=%0d at=%0d required 1 at 17", round, f, fa);
            end
            checks++;
            if ({ones, tens, hundreds, thousands} !== 16'h9528 || digit_valid !== 4'b1111
                || e_tot !== 0) begin
                failures++;
                $display("FAIL frame_digits r%0d: got %h dv=%b errs=%0d required 9528 1111 0",
                         round, {ones, tens, hundreds, thousands}, digit_valid, e_tot);
            end
        end
    endtask

    task automatic test_glitch();
        int e1, e2, f, fa;
        hold(4'b1110, P2, 10, e1, f, fa);
        checks++;
        if (ones !== 4'd9) begin failures++; $display("FAIL glitch_short: ones=%0d required 9", ones); end
        hold(4'b1110, P3, 40, e2, f, fa);
        checks++;
        if (ones !== 4'd3 || e1 !== 0 || e2 !== 0) begin
            failures++;
            $display("FAIL glitch_second: ones=%0d errs=%0d/%0d required 3 0/0", ones, e1, e2);
        end
    endtask

    task automatic test_bad_seg();
        int e, f, fa;
        hold(4'b1101, PBLANK, 30, e, f, fa);
        checks++;
        if (e !== 1 || err_sticky !== 2'b01 || tens !== 4'd5 || digit_valid[1] !== 1'b0) begin
            failures++;
            $display("FAIL bad_seg: errs=%0d es=%b tens=%0d dv=%b required 1 01 5 x0x",
                     e, err_sticky, tens, digit_valid);
        end
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        checks++;
        if (err_sticky !== 2'b00) begin
            failures++;
            $display("FAIL clr_err: es=%b required 00", err_sticky);
        end
    endtask

    task automatic test_bad_anode();
        int e, f, fa;
        hold(4'b1100, P4, 30, e, f, fa);
        checks++;
        if (e !== 1 || err_sticky !== 2'b10 || {ones, tens, hundreds, thousands} !== 16'h3528) begin
            failures++;
            $display("FAIL bad_anode: errs=%0d es=%b digits=%h required 1 10 3528",
                     e, err_sticky, {ones, tens, hundreds, thousands});
        end
        hold(4'b1111, P4, 30, e, f, fa);
        checks++;
        if (e !== 0 || err_sticky !== 2'b10 || {ones, tens, hundreds, thousands} !== 16'h3528) begin
            failures++;
            $display("FAIL blank_anode: errs=%0d es=%b digits=%h required 0 10 3528",
                     e, err_sticky, {ones, tens, hundreds, thousands});
        end
    endtask

    task automatic test_stale();
        int e, f, fa, target;
        hold(4'b1110, P0, 30, e, f, fa);
        hold(4'b1101, P6, 30, e, f, fa);
        hold(4'b1011, P7, 30, e, f, fa);
        hold(4'b0111, P9, 30, e, f, fa);
        checks++;
        if (f !== 1 || fa !== 17) begin
            failures++;
            $display("FAIL stale_frame: frames=%0d at=%0d required 1 at 17", f, fa);
        end
        // Last accepted capture happened (30 - fa) cycles ago.
        target = TIMEOUT - (30 - fa);
        an  = 4'b1111;
        seg = PBLANK;
        tick(target - 1);
        checks++;
        if (stale !== 1'b0 || digit_valid !== 4'b1111) begin
            failures++;
            $display("FAIL stale_early: stale=%b dv=%b required 0 1111", stale, digit_valid);
        end
        tick(1);
        checks++;
        if (stale !== 1'b1 || digit_valid !== 4'b0000) begin
            failures++;
            $display("FAIL stale_set: stale=%b dv=%b required 1 0000", stale, digit_valid);
        end
        hold(4'b1101, P4, 30, e, f, fa);
        checks++;
        if (stale !== 1'b0 || digit_valid !== 4'b0010 || tens !== 4'd4) begin
            failures++;
            $display("FAIL stale_clear: stale=%b dv=%b tens=%0d required 0 0010 4",
                     stale, digit_valid, tens);
        end
    endtask

    task automatic test_reset_mid_frame();
        int e, f, fa;
        hold(4'b1011, P6, 30, e, f, fa);
        hold(4'b0111, P3, 10, e, f, fa);
        RESET = 1'b1;
        #1;
        checks++;
        if ({ones, tens, hundreds, thousands, digit_valid, frame_valid, err, err_sticky, stale}
            !== '0) begin
            failures++;
            $display("FAIL reset_mid: got %h %h %h %h dv=%b fv=%b err=%b es=%b stale=%b",
                     ones, tens, hundreds, thousands, digit_valid, frame_valid, err,
                     err_sticky, stale);
        end
        tick(2);
        RESET = 1'b0;
        hold(4'b0111, P3, 30, e, f, fa);
        checks++;
        if (thousands !== 4'd3 || digit_valid !== 4'b1000) begin
            failures++;
            $display("FAIL reset_recover: thousands=%0d dv=%b required 3 1000",
                     thousands, digit_valid);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_frames();
        test_glitch();
        test_bad_seg();
        test_bad_anode();
        test_stale();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_display_decoder.md
# seg_display_decoder

Recovers the four BCD digits from a multiplexed, active-low 7-segment bus (seg[0:6] with a..g in bit order 0..6, and an[3:0]), producing ones/tens/hundreds/thousands values. It sits on the display side of the lab 4 design as the inverse of the digit-multiplexing display driver. Typical uses are on-board self-check and loopback of the display bus. It rejects transition glitches, flags illegal patterns and anode codes, and reports when the bus has gone stale.

## Interface
- STABLE_CYCLES, 16, consecutive identical samples required before a capture (minimum 2)
- TIMEOUT, 400_000, cycles without an accepted capture before the output is declared stale
- clk  in  1  system clock (100 MHz)
- RESET  in  1  asynchronous, active-high reset
- seg  in  [0:6]  segment bus, active-low (0 = lit), bit 0 = segment a
- an  in  [3:0]  anode bus, active-low one-hot: 1110 ones, 1101 tens, 1011 hundreds, 0111 thousands
- clr_err  in  1  synchronous clear of err_sticky
- ones, tens, hundreds, thousands  out  [3:0] each  last accepted BCD value per position
- digit_valid  out  [3:0]  bit i = position i holds a valid value (bit 0 = ones)
- frame_valid  out  1  one-cycle pulse when all four positions have been captured since the last frame
- err  out  1  one-cycle pulse on a rejected capture
- err_sticky  out  [1:0]  bit0 = illegal seg pattern seen, bit1 = illegal anode seen
- stale  out  1  no accepted capture for TIMEOUT cycles

## Operation
- Input stage: seg and an are registered every cycle into sample registers.
- Stability counter: resets to 0 whenever the sample differs from the previous sample; otherwise increments, saturating at STABLE_CYCLES. The counter width is $clog2(STABLE_CYCLES+1).
- Capture: occurs exactly once per stable window, on the edge where the counter goes from STABLE_CYCLES-1 to STABLE_CYCLES. No further capture happens until the sample changes.
- Anode check at capture:
  - an = 1111 (blanked) is ignored with no error.
  - Any other non-one-hot-low code is rejected: err pulse, err_sticky[1] set, no digit update.
- Pattern decode, active-low:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
- Unmatched pattern: err pulse, err_sticky[0] set. The selected digit register is unchanged, and its digit_valid bit and seen bit are cleared.
- Accepted capture:
  - Write the digit register selected by an.
  - Set the corresponding digit_valid and internal seen bits.
  - Clear stale and reset the timeout counter.
- Frame: on the accepted capture that makes seen = 1111, frame_valid pulses on that same edge and seen clears to 0000.
- Timeout: a counter increments every cycle without an accepted capture. On reaching TIMEOUT-1:
  - stale is set and digit_valid and seen clear.
  - The counter holds until the next accepted capture.
- clr_err clears err_sticky. If a new error occurs on the same cycle, the new error bit wins.

## Timing
- Reset values: all digit registers 0, digit_valid 0000, frame_valid 0, err 0, err_sticky 00, stale 0, all counters 0, seen 0000, sample registers seg = 1111111 and an = 1111.
- Latency: if the pins settle before edge N, digit outputs update at edge N+STABLE_CYCLES, i.e. visible STABLE_CYCLES+1 cycles after the pins settle.
- Any pin change before the counter reaches STABLE_CYCLES-1 suppresses the capture.
- err and frame_valid are registered single-cycle pulses aligned with the capture edge.
- RESET mid-frame returns every output to its reset value immediately. Capture restarts only after STABLE_CYCLES stable samples.
- Sustained capture rate: at most one per STABLE_CYCLES+1 cycles. A 100_000-cycle digit period is always captured.

## Test plan
- Ones held at 7 (an=1110, seg=0001111) for 30 cycles, STABLE_CYCLES=16 -> ones=7 and digit_valid=0001 exactly 17 cycles after the change, err=0, frame_valid=0.
- Cycle 1110/9, 1101/5, 1011/2, 0111/8, 200 cycles each -> ones=9, tens=5, hundreds=2, thousands=8; one frame_valid pulse on the thousands capture edge; second round produces a second pulse.
- Pattern held 10 cycles, then a different pattern -> no capture from the first; second captured normally; err stays 0.
- Tens with seg=1111111 held 30 cycles -> err pulses once, err_sticky=01, tens unchanged, digit_valid[1]=0; clr_err for one cycle -> err_sticky=00.
- an=1100 held 30 cycles -> err pulse, err_sticky=10; an=1111 held 30 cycles -> no err and no change.
- Valid frame followed by 1111 for TIMEOUT cycles -> stale=1 and digit_valid=0000 at cycle TIMEOUT; next valid capture clears stale. RESET asserted mid-frame -> all outputs return to reset values.
